// File: rtl/max6951_rx_pkg.sv
// Shared constants for the MAX6951 receive-side mirror: register map, reset values,
// FSM state encoding and the hex font used by the optional segment decoder.
package max6951_pkg;

  localparam logic [7:0] ADDR_DECODE    = 8'h01;
  localparam logic [7:0] ADDR_INTENSITY = 8'h02;
  localparam logic [7:0] ADDR_SCAN      = 8'h03;
  localparam logic [7:0] ADDR_CONFIG    = 8'h04;
  // Digit registers live at 0x20-0x27 and 0x60-0x67; addr[2:0] picks the digit.
  localparam logic [4:0] DIGIT_BANK_A   = 5'b00100;
  localparam logic [4:0] DIGIT_BANK_B   = 5'b01100;

  localparam logic [4:0] FRAME_BITS     = 5'd16;
  localparam logic [4:0] CNT_SAT        = 5'd17;
  localparam logic [7:0] REG_RST        = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  // Segment bits {a,b,c,d,e,f,g}; entry 0 in the low 7 bits.
  localparam logic [16*7-1:0] HEX_FONT = {
    7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
    7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
  };

  function automatic logic [6:0] hex_font(input logic [3:0] nib);
    return HEX_FONT[nib*7 +: 7];
  endfunction

endpackage

// File: rtl/max6951_rx_if.sv
// Serial bus of the MAX6951 3-wire interface as seen between display driver and receiver.
// Framing: DI_nCS low opens a frame, DI_DTA is sampled on each DI_CKS rising edge
// (MSB first), and DI_nCS returning high closes it; there is no back-pressure.
interface max6951_rx_if;
  logic DI_nCS;
  logic DI_DTA;
  logic DI_CKS;

  modport master (output DI_nCS, output DI_DTA, output DI_CKS);
  modport slave  (input  DI_nCS, input  DI_DTA, input  DI_CKS);
endinterface

// File: rtl/max6951_rx_sync.sv
// Multi-stage synchroniser for nCS/DTA/CKS plus CKS rising-edge detect on the
// synchronised domain. SYNC_STAGES must be at least 2.
module max6951_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_ncs,
  input  logic i_dta,
  input  logic i_cks,
  output logic o_ncs,
  output logic o_dta,
  output logic o_cks_rise
);

  logic [SYNC_STAGES-1:0] r_ncs;
  logic [SYNC_STAGES-1:0] r_dta;
  logic [SYNC_STAGES-1:0] r_cks;
  logic                   r_cks_prev;

  // nCS resets to the idle (deselected) level so reset itself never opens a frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ncs      <= '1;
      r_dta      <= '0;
      r_cks      <= '0;
      r_cks_prev <= 1'b0;
    end else begin
      r_ncs      <= {r_ncs[SYNC_STAGES-2:0], i_ncs};
      r_dta      <= {r_dta[SYNC_STAGES-2:0], i_dta};
      r_cks      <= {r_cks[SYNC_STAGES-2:0], i_cks};
      r_cks_prev <= r_cks[SYNC_STAGES-1];
    end
  end

  assign o_ncs      = r_ncs[SYNC_STAGES-1];
  assign o_dta      = r_dta[SYNC_STAGES-1];
  assign o_cks_rise = r_cks[SYNC_STAGES-1] & ~r_cks_prev;

endmodule

// File: rtl/max6951_rx.sv
// MAX6951 receiver: deserialises 16-bit frames and mirrors the display registers.
// Optional segment decoder enabled by defining MAX6951_RX_SEGDEC_EN.
module max6951_rx
  import max6951_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  max6951_rx_if.slave  bus,
  output logic [31:0]  digits,
  output logic [7:0]   dps,
  output logic [7:0]   decode_mode,
  output logic [3:0]   intensity,
  output logic [2:0]   scan_limit,
  output logic [7:0]   config_out,  // "config" is a reserved word
  output logic         frame_valid,
  output logic         frame_err,
  output logic [7:0]   frame_addr,
  output logic [7:0]   frame_data,
  output logic [63:0]  segments,
  output state_t       dbg_state
);

  logic w_ncs, w_dta, w_cks_rise;

  max6951_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .reset      (reset),
    .i_ncs      (bus.DI_nCS),
    .i_dta      (bus.DI_DTA),
    .i_cks      (bus.DI_CKS),
    .o_ncs      (w_ncs),
    .o_dta      (w_dta),
    .o_cks_rise (w_cks_rise)
  );

  state_t      r_state, w_next;
  logic [15:0] r_shift;
  logic [4:0]  r_cnt;
  logic        w_commit, w_err;
  logic [7:0]  w_addr, w_data;

  logic [7:0]  r_digit [8];
  logic [7:0]  r_decode, r_config, r_faddr, r_fdata;
  logic [3:0]  r_intensity;
  logic [2:0]  r_scan;
  logic        r_fv, r_fe;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_commit = 1'b0;
    w_err    = 1'b0;
    unique case (r_state)
      ST_IDLE:  if (!w_ncs) w_next = ST_SHIFT;
      ST_SHIFT: if (w_ncs)  w_next = ST_CHECK;
      ST_CHECK: begin
        w_next   = ST_IDLE;
        w_commit = (r_cnt == FRAME_BITS);
        w_err    = (r_cnt != FRAME_BITS) && (r_cnt != 5'd0);
      end
      default:  w_next = ST_IDLE;
    endcase
  end

  assign w_addr = r_shift[15:8];
  assign w_data = r_shift[7:0];

  // A CKS edge coinciding with nCS rising is still shifted before CHECK counts it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift     <= '0;
      r_cnt       <= '0;
      r_fv        <= 1'b0;
      r_fe        <= 1'b0;
      r_faddr     <= REG_RST;
      r_fdata     <= REG_RST;
      r_decode    <= REG_RST;
      r_config    <= REG_RST;
      r_intensity <= '0;
      r_scan      <= '0;
      for (int i = 0; i < 8; i++) r_digit[i] <= REG_RST;
    end else begin
      r_fv <= w_commit;
      r_fe <= w_err;
      if (r_state == ST_IDLE) begin
        r_shift <= '0;
        r_cnt   <= '0;
      end else if (r_state == ST_SHIFT && w_cks_rise) begin
        r_shift <= {r_shift[14:0], w_dta};
        if (r_cnt != CNT_SAT) r_cnt <= r_cnt + 5'd1;
      end
      if (w_commit) begin
        r_faddr <= w_addr;
        r_fdata <= w_data;
        case (w_addr)
          ADDR_DECODE:    r_decode    <= w_data;
          ADDR_INTENSITY: r_intensity <= w_data[3:0];
          ADDR_SCAN:      r_scan      <= w_data[2:0];
          ADDR_CONFIG:    r_config    <= w_data;
          default: begin
            if (w_addr[7:3] == DIGIT_BANK_A || w_addr[7:3] == DIGIT_BANK_B)
              r_digit[w_addr[2:0]] <= w_data;
          end
        endcase
      end
    end
  end

  always_comb begin
    digits = '0;
    dps    = '0;
    for (int i = 0; i < 8; i++) begin
      digits[31-4*i -: 4] = r_digit[i][3:0];
      dps[7-i]            = r_digit[i][7];
    end
  end

`ifdef MAX6951_RX_SEGDEC_EN
  logic [63:0] r_seg;

  // decode_mode bit i selects font decoding for digit register 0x60+i.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_seg <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (r_decode[i]) r_seg[63-8*i -: 8] <= {r_digit[i][7], hex_font(r_digit[i][3:0])};
        else             r_seg[63-8*i -: 8] <= r_digit[i];
      end
    end
  end

  assign segments = r_seg;
`else
  assign segments = '0;
`endif

  assign decode_mode = r_decode;
  assign intensity   = r_intensity;
  assign scan_limit  = r_scan;
  assign config_out  = r_config;
  assign frame_valid = r_fv;
  assign frame_err   = r_fe;
  assign frame_addr  = r_faddr;
  assign frame_data  = r_fdata;
  assign dbg_state   = r_state;

endmodule
